// File: rtl/uop_sequencer.sv
// Microcode sequencer: walks a routine in the uop buffer one WIDTH-uop bundle per cycle
// and queues address/tag/end-mask tagged bundles toward decode through a DEPTH-entry FIFO.
module uop_sequencer #(
  parameter int UOP_BUF_SIZE = 256,
  parameter int WIDTH        = 2,
  parameter int UOP_BITS     = 32,
  parameter int DEPTH        = 4,
  parameter int TAG_BITS     = 2,
  localparam int AW          = $clog2(UOP_BUF_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AW-1:0]             start_addr,
  input  logic                      redirect,
  input  logic [AW-1:0]             redirect_addr,
  input  logic [TAG_BITS-1:0]       redirect_tag,
  output logic                      uop_rd_en,
  output logic [AW-1:0]             uop_addr,
  input  logic [WIDTH*UOP_BITS-1:0] uop_data,
  input  logic [WIDTH-1:0]          uop_end,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*UOP_BITS-1:0] out_uops,
  output logic [WIDTH-1:0]          out_mask,
  output logic                      out_end,
  output logic [AW-1:0]             out_addr,
  output logic [TAG_BITS-1:0]       out_tag,
  output logic                      busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [AW-1:0] ALIGN   = ~AW'(WIDTH - 1);
  localparam logic [AW-1:0] STEP    = AW'(WIDTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [0:0]          state;
  logic [AW-1:0]       pc;
  logic [TAG_BITS-1:0] cur_tag;
  logic                inflight;
  logic                inflight_kill;
  logic [AW-1:0]       inflight_addr;
  logic [TAG_BITS-1:0] inflight_tag;
  logic [CW-1:0]       count;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;

  logic [WIDTH*UOP_BITS-1:0] uops_mem [DEPTH];
  logic [WIDTH-1:0]          mask_mem [DEPTH];
  logic                      end_mem  [DEPTH];
  logic [AW-1:0]             addr_mem [DEPTH];
  logic [TAG_BITS-1:0]       tag_mem  [DEPTH];

  logic [CW:0]      credit_used;
  logic             ret_valid;
  logic             ret_end;
  logic             pop;
  logic [WIDTH-1:0] ret_mask;
  logic             end_seen;

  // The in-flight read already holds a FIFO slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign uop_rd_en   = (state == RUN) && !redirect && (credit_used < DEPTH_C);
  assign uop_addr    = pc;

  assign ret_valid = inflight && !inflight_kill && !redirect;
  assign ret_end   = |uop_end;
  assign pop       = out_valid && out_ready && !redirect;

  // Slots up to and including the first end-of-routine uop are valid.
  always_comb begin
    ret_mask = '0;
    end_seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ret_mask[i] = ~end_seen;
      end_seen    = end_seen | uop_end[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= '0;
      cur_tag       <= '0;
      inflight      <= 1'b0;
      inflight_kill <= 1'b0;
      inflight_addr <= '0;
      inflight_tag  <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else if (redirect) begin
      state         <= RUN;
      pc            <= redirect_addr & ALIGN;
      cur_tag       <= redirect_tag;
      inflight      <= 1'b0;
      inflight_kill <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      inflight      <= uop_rd_en;
      // A read issued alongside the terminating bundle is past the routine end.
      inflight_kill <= uop_rd_en && ret_valid && ret_end;
      if (uop_rd_en) begin
        inflight_addr <= pc;
        inflight_tag  <= cur_tag;
      end

      if (state == IDLE && start) begin
        state   <= RUN;
        pc      <= start_addr & ALIGN;
        cur_tag <= '0;
      end else begin
        if (uop_rd_en && !(ret_valid && ret_end)) begin
          pc <= pc + STEP;
        end
        if (ret_valid && ret_end) begin
          state <= IDLE;
        end
      end

      if (ret_valid) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({ret_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage is cleared on reset so the head outputs read as zero when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        uops_mem[i] <= '0;
        mask_mem[i] <= '0;
        end_mem[i]  <= 1'b0;
        addr_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (ret_valid) begin
      uops_mem[wr_ptr] <= uop_data;
      mask_mem[wr_ptr] <= ret_mask;
      end_mem[wr_ptr]  <= ret_end;
      addr_mem[wr_ptr] <= inflight_addr;
      tag_mem[wr_ptr]  <= inflight_tag;
    end
  end

  assign out_valid = (count != '0);
  assign out_uops  = uops_mem[rd_ptr];
  assign out_mask  = mask_mem[rd_ptr];
  assign out_end   = end_mem[rd_ptr];
  assign out_addr  = addr_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];
  assign busy      = (state == RUN) || inflight || out_valid;

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: directed table of routines, multi-cycle corner
// sequences, and randomized routines/redirects scored against a bundle-level reference model.
module tb_uop_sequencer;

  localparam int UBS = 16;
  localparam int W   = 2;
  localparam int UB  = 32;
  localparam int D   = 4;
  localparam int TW  = 2;
  localparam int AW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic              redirect;
  logic [AW-1:0]     redirect_addr;
  logic [TW-1:0]     redirect_tag;
  logic              uop_rd_en;
  logic [AW-1:0]     uop_addr;
  logic [W*UB-1:0]   uop_data;
  logic [W-1:0]      uop_end;
  logic              out_valid;
  logic              out_ready;
  logic [W*UB-1:0]   out_uops;
  logic [W-1:0]      out_mask;
  logic              out_end;
  logic [AW-1:0]     out_addr;
  logic [TW-1:0]     out_tag;
  logic              busy;

  uop_sequencer #(
    .UOP_BUF_SIZE(UBS), .WIDTH(W), .UOP_BITS(UB), .DEPTH(D), .TAG_BITS(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .redirect(redirect), .redirect_addr(redirect_addr), .redirect_tag(redirect_tag),
    .uop_rd_en(uop_rd_en), .uop_addr(uop_addr), .uop_data(uop_data), .uop_end(uop_end),
    .out_valid(out_valid), .out_ready(out_ready), .out_uops(out_uops), .out_mask(out_mask),
    .out_end(out_end), .out_addr(out_addr), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [W-1:0]    mask;
    logic            end_f;
    logic [TW-1:0]   tag;
    logic [W*UB-1:0] uops;
  } bundle_t;

  typedef struct {
    logic [AW-1:0] start_addr;
    int            end_uop;
    int            exp_n;
    logic [AW-1:0] exp_last_addr;
    logic [W-1:0]  exp_last_mask;
  } vec_t;

  logic [UB-1:0] mem_data [UBS];
  logic          mem_end  [UBS];

  bundle_t       exp_q[$];
  bundle_t       popped_q[$];
  logic [AW-1:0] issued[$];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int last_pop_cycle = 0;
  int idle_cycle = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: a routine is consecutive aligned bundles up to the first one holding an end flag.
  function automatic void buildRoutine(input logic [AW-1:0] a, input logic [TW-1:0] tag);
    logic [AW-1:0] p;
    logic [AW-1:0] p1;
    bundle_t       b;
    p = a & 4'hE;
    for (int k = 0; k < UBS / W; k++) begin
      p1      = p + 4'd1;
      b.addr  = p;
      b.tag   = tag;
      b.uops  = {mem_data[p1], mem_data[p]};
      b.end_f = mem_end[p] | mem_end[p1];
      b.mask  = mem_end[p] ? 2'b01 : 2'b11;
      exp_q.push_back(b);
      if (b.end_f) break;
      p = p + 4'd2;
    end
  endfunction

  task automatic fillMem(input int end_uop);
    foreach (mem_data[i]) begin
      mem_data[i] = $urandom;
      mem_end[i]  = 1'b0;
    end
    if (end_uop >= 0) mem_end[end_uop] = 1'b1;
  endtask

  task automatic applyStimulus(input logic st, input logic [AW-1:0] sa, input logic rd,
                               input logic [AW-1:0] ra, input logic [TW-1:0] rt,
                               input logic rdy);
    @(posedge clk);
    #1;
    start         = st;
    start_addr    = sa;
    redirect      = rd;
    redirect_addr = ra;
    redirect_tag  = rt;
    out_ready     = rdy;
  endtask

  task automatic startRoutine(input logic [AW-1:0] a, input logic rdy);
    buildRoutine(a, 2'd0);
    applyStimulus(1'b1, a, 1'b0, 4'd0, 2'd0, rdy);
    applyStimulus(1'b0, a, 1'b0, 4'd0, 2'd0, rdy);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    #1;
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_left"}, exp_q.size(), 0);
  endtask

  // Uop buffer model: read data appears the cycle after the request, garbage otherwise.
  initial begin : mem_model
    logic          cap_en;
    logic [AW-1:0] cap_addr;
    logic [AW-1:0] cap_addr1;
    cap_en   = 1'b0;
    cap_addr = '0;
    uop_data = '0;
    uop_end  = '0;
    forever begin
      @(negedge clk);
      cap_en   = uop_rd_en;
      cap_addr = uop_addr;
      @(posedge clk);
      #1;
      if (cap_en) begin
        cap_addr1 = cap_addr + 4'd1;
        uop_data  = {mem_data[cap_addr1], mem_data[cap_addr]};
        uop_end   = {mem_end[cap_addr1], mem_end[cap_addr]};
      end else begin
        uop_data = {$urandom, $urandom};
        uop_end  = 2'($urandom);
      end
    end
  end

  // Scoreboard: every accepted head bundle must match the front of the expected queue.
  initial begin : monitor
    bundle_t act;
    bundle_t exp;
    logic    prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        if (uop_rd_en) issued.push_back(uop_addr);
        if (redirect) begin
          exp_q.delete();
          buildRoutine(redirect_addr, redirect_tag);
        end else if (out_valid && out_ready) begin
          act = {out_addr, out_mask, out_end, out_tag, out_uops};
          exp = 'x;
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          checkOutput("pop_bundle", act, exp);
          popped_q.push_back(act);
          last_pop_cycle = cycle;
        end
        if (prev_busy && !busy) idle_cycle = cycle;
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t          vecs[5];
    logic [AW-1:0] sa;
    logic [AW-1:0] ra;
    logic [AW-1:0] ra_last;
    logic [TW-1:0] rt;
    logic          rd;
    logic          rdy;
    logic          prev_rd;
    int            redirs;
    int            n;

    vecs[0] = '{4'd4,  8, 3, 4'd8, 2'b01};
    vecs[1] = '{4'd14, 1, 2, 4'd0, 2'b11};
    vecs[2] = '{4'd5,  5, 1, 4'd4, 2'b11};
    vecs[3] = '{4'd0,  0, 1, 4'd0, 2'b01};
    vecs[4] = '{4'd10, 9, 8, 4'd8, 2'b11};

    fillMem(-1);
    reset         = 1'b0;
    start         = 1'b1;
    start_addr    = 4'd4;
    redirect      = 1'b0;
    redirect_addr = '0;
    redirect_tag  = '0;
    out_ready     = 1'b1;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  {uop_rd_en, uop_addr, out_valid, out_uops, out_mask, out_end, out_addr,
                   out_tag, busy}, 0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {busy, uop_rd_en, out_valid}, 0);
    end

    // Directed routines from the table, consumer always ready.
    foreach (vecs[v]) begin
      fillMem(vecs[v].end_uop);
      issued.delete();
      popped_q.delete();
      startRoutine(vecs[v].start_addr, 1'b1);
      waitIdle("table");
      checkOutput("table_count", popped_q.size(), vecs[v].exp_n);
      if (popped_q.size() > 0) begin
        checkOutput("table_last_addr", popped_q[$].addr, vecs[v].exp_last_addr);
        checkOutput("table_last_mask", popped_q[$].mask, vecs[v].exp_last_mask);
        checkOutput("table_last_end", popped_q[$].end_f, 1);
      end
      checkOutput("table_issue_count", issued.size(), vecs[v].exp_n + 1);
      for (int k = 0; k < issued.size() && k <= vecs[v].exp_n; k++) begin
        checkOutput("table_issue_addr", issued[k],
                    ((vecs[v].start_addr & 4'hE) + 2 * k) % UBS);
      end
      checkOutput("busy_fall", idle_cycle - last_pop_cycle, 1);
    end

    // Backpressure: four credits fill the FIFO, then the front end stalls.
    fillMem(15);
    issued.delete();
    popped_q.delete();
    startRoutine(4'd0, 1'b0);
    repeat (7) applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("bp_issue_count", issued.size(), 4);
    if (issued.size() >= 4)
      checkOutput("bp_issue_addrs", {issued[0], issued[1], issued[2], issued[3]}, 16'h0246);
    checkOutput("bp_stalled", {uop_rd_en, out_valid, out_addr}, {1'b0, 1'b1, 4'd0});
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
    waitIdle("bp");
    checkOutput("bp_drain_count", popped_q.size(), 8);
    checkOutput("bp_resume_addr", issued.size() > 4 ? issued[4] : 'x, 8);

    // Redirect with three bundles queued and a read in flight.
    fillMem(15);
    issued.delete();
    popped_q.delete();
    startRoutine(4'd0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (issued.size() < 4) applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    end while (issued.size() < 4 && n < 20);
    checkOutput("redir_setup", issued.size(), 4);
    checkOutput("redir_setup_valid", out_valid, 1);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd6, 2'd2, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("redir_flush", {out_valid, uop_rd_en, uop_addr}, {1'b0, 1'b1, 4'd6});
    waitIdle("redir");
    checkOutput("redir_count", popped_q.size(), 5);
    if (popped_q.size() > 0)
      checkOutput("redir_first", {popped_q[0].addr, popped_q[0].tag}, {4'd6, 2'd2});

    // start and redirect together from IDLE: redirect wins; a later start in RUN is ignored.
    fillMem(15);
    issued.delete();
    popped_q.delete();
    applyStimulus(1'b1, 4'd2, 1'b1, 4'd10, 2'd1, 1'b1);
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("collide_first_read", {uop_rd_en, uop_addr}, {1'b1, 4'd10});
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
    waitIdle("collide");
    checkOutput("collide_count", popped_q.size(), 3);
    checkOutput("collide_issue0", issued.size() > 0 ? issued[0] : 'x, 10);

    // Randomized routines with random backpressure and occasional redirects.
    for (int r = 0; r < 30; r++) begin
      fillMem(-1);
      foreach (mem_end[i]) mem_end[i] = ($urandom_range(0, 4) == 0);
      mem_end[$urandom_range(0, 15)] = 1'b1;
      sa = 4'($urandom);
      startRoutine(sa, 1'b1);
      redirs  = 0;
      prev_rd = 1'b0;
      ra_last = '0;
      n       = 0;
      do begin
        rdy = ($urandom_range(0, 3) != 0);
        rd  = !prev_rd && (redirs < 2) && ($urandom_range(0, 19) == 0);
        ra  = 4'($urandom);
        rt  = 2'($urandom);
        applyStimulus(1'b0, 4'($urandom), rd, ra, rt, rdy);
        @(negedge clk);
        if (prev_rd) begin
          checkOutput("rnd_redir_valid", out_valid, 0);
          checkOutput("rnd_redir_addr", uop_addr, ra_last & 4'hE);
        end
        if (rd) begin
          redirs++;
          ra_last = ra;
        end
        prev_rd = rd;
        n++;
      end while ((busy || rd) && n < 400);
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1);
      waitIdle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
